// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/192/256 block encryptor, one round per clock; round keys are fetched by index.
// Accepts a block every Nr+2 cycles; a stalled round key freezes the core and the result is held until taken.
module aes_encrypt_iter #(
  parameter int DATA_WIDTH     = 128,
  parameter int KEY_ADDR_WIDTH = 4,
  parameter int MAX_KEY_LEN    = 2
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic [1:0]                key_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     round_key,
  input  logic                      round_key_rdy,
  output logic [KEY_ADDR_WIDTH-1:0] round_key_addr,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [3:0]            nr;
  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] st;
  logic [DATA_WIDTH-1:0] sr;
  logic [DATA_WIDTH-1:0] mc;
  logic [1:0]            kl;
  logic                  accept;

  // Entry b sits at bits [8*(255-b) +: 8]; ~b is 255-b for a byte.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127 - 8*(4*c + w) -: 8] = sbox(s[127 - 8*(4*((c + w) % 4) + w) -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127 - 32*c -: 32];
      r[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r;
  endfunction

  // One SubBytes/ShiftRows path feeds both the full rounds and the final round.
  assign sr = sub_shift(st);
  assign mc = mix_cols(sr);

  assign kl       = (key_len > 2'(MAX_KEY_LEN)) ? 2'(MAX_KEY_LEN) : key_len;
  assign in_ready = !Rst && (state == IDLE || (state == DONE && out_ready));
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    round_key_addr = '0;
    case (state)
      ROUND:   round_key_addr = KEY_ADDR_WIDTH'(cnt);
      FINAL:   round_key_addr = KEY_ADDR_WIDTH'(nr);
      default: round_key_addr = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      nr        <= 4'd10;
      data      <= '0;
      st        <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          data  <= data_in;
          nr    <= 4'd10 + {1'b0, kl, 1'b0};
          state <= INIT;
        end
        INIT: if (round_key_rdy) begin
          st    <= data ^ round_key;
          cnt   <= 4'd1;
          state <= ROUND;
        end
        ROUND: if (round_key_rdy) begin
          st  <= mc ^ round_key;
          cnt <= cnt + 4'd1;
          if (cnt == nr - 4'd1) state <= FINAL;
        end
        FINAL: if (round_key_rdy) begin
          data_out  <= sr ^ round_key;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          // A block offered while the result drains starts immediately.
          if (accept) begin
            data  <= data_in;
            nr    <= 4'd10 + {1'b0, kl, 1'b0};
            state <= INIT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: FIPS-197 vectors plus random blocks against a GF(2^8)-derived AES model.
module tb_aes_encrypt_iter;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192   = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam int           NOSTALL = 99;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] data_in;
  logic [1:0]   key_len;
  logic         in_valid, in_ready;
  logic [127:0] round_key;
  logic         round_key_rdy;
  logic [3:0]   round_key_addr;
  logic [127:0] data_out;
  logic         out_valid, out_ready, busy;
  logic         in_valid0, in_ready0, out_valid0, busy0;
  logic [127:0] round_key0, data_out0;
  logic [3:0]   round_key_addr0;

  logic [127:0] rk_mem [16];
  logic [7:0]   sb [256];
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  // Key-schedule store model: answers whatever index each core requests.
  assign round_key  = rk_mem[round_key_addr];
  assign round_key0 = rk_mem[round_key_addr0];

  aes_encrypt_iter dut (
    .Clk(clk), .Rst(rst), .data_in(data_in), .key_len(key_len),
    .in_valid(in_valid), .in_ready(in_ready), .round_key(round_key),
    .round_key_rdy(round_key_rdy), .round_key_addr(round_key_addr),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  aes_encrypt_iter #(.MAX_KEY_LEN(0)) dut_k0 (
    .Clk(clk), .Rst(rst), .data_in(data_in), .key_len(key_len),
    .in_valid(in_valid0), .in_ready(in_ready0), .round_key(round_key0),
    .round_key_rdy(round_key_rdy), .round_key_addr(round_key_addr0),
    .data_out(data_out0), .out_valid(out_valid0), .out_ready(out_ready), .busy(busy0)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic load_key(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 4*(nr + 1); i++) begin
      if (i < nk) begin
        w[i] = key[255 - 32*i -: 32];
      end else begin
        tmp = w[i-1];
        if (i % nk == 0) begin
          tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
          rc  = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          tmp = subword(tmp);
        end
        w[i] = w[i-nk] ^ tmp;
      end
    end
    for (int r = 0; r <= nr; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] cipher(input logic [127:0] pt, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] v;
    v = pt ^ rk_mem[0];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[v[127 - 8*i -: 8]];
      for (int i = 0; i < 16; i++) t[i] = s[(i % 4) + 4*(((i / 4) + (i % 4)) % 4)];
      if (r < nr) begin
        for (int c = 0; c < 4; c++)
          for (int j = 0; j < 4; j++)
            s[4*c+j] = gmul(8'h02, t[4*c+j]) ^ gmul(8'h03, t[4*c+(j+1)%4])
                     ^ t[4*c+(j+2)%4] ^ t[4*c+(j+3)%4];
      end else begin
        s = t;
      end
      for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = s[i];
      v = v ^ rk_mem[r];
    end
    return v;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] pt, input logic [1:0] kl, input string tag);
    data_in = pt; key_len = kl; in_valid = 1'b1;
    check({tag, " in_ready idle"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    key_len  = 2'($urandom);
  endtask

  // Latency counts the accept edge as edge 1; out_valid is first seen after edge Nr+2 (+ stalls).
  task automatic wait_result(input int nr, input int stall_addr, input int stall_n,
                             input logic [127:0] exp, input string tag);
    int   edges, left;
    logic bad, stalled;
    edges = 1; left = stall_n; bad = 1'b0;
    while (out_valid !== 1'b1 && edges < 64) begin
      if (in_ready !== 1'b0 || busy !== 1'b1 || int'(round_key_addr) > nr) bad = 1'b1;
      stalled = (left > 0 && int'(round_key_addr) == stall_addr);
      if (stalled) left--;
      round_key_rdy = !stalled;
      in_valid = 1'($urandom);
      data_in  = rnd128();
      step();
      edges++;
      if (stalled && int'(round_key_addr) != stall_addr) bad = 1'b1;
    end
    round_key_rdy = 1'b1;
    in_valid = 1'b0;
    check({tag, " latency"}, edges, nr + 2 + stall_n);
    check({tag, " flow"}, bad, 0);
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " data_out"}, data_out, exp);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    step();
    check({tag, " out_valid drop"}, out_valid, 0);
    check({tag, " idle"}, busy, 0);
  endtask

  task automatic run(input logic [127:0] pt, input logic [1:0] kl, input logic [255:0] key,
                     input int nk, input int stall_addr, input int stall_n,
                     input logic [127:0] exp, input string tag);
    load_key(key, nk);
    send(pt, kl, tag);
    wait_result(nk + 6, stall_addr, stall_n, exp, tag);
    consume(tag);
  endtask

  initial begin
    logic [127:0] pt_b, pt;
    logic [255:0] key;
    logic [1:0]   kl;
    logic         bad;
    int           nk, edges;

    rst = 1'b1; data_in = '0; key_len = 2'd0; in_valid = 1'b0; in_valid0 = 1'b0;
    out_ready = 1'b1; round_key_rdy = 1'b1;
    for (int i = 0; i < 16; i++) rk_mem[i] = '0;
    build_sbox();
    step(); step();
    check("reset busy", busy, 0);
    check("reset out_valid", out_valid, 0);
    check("reset data_out", data_out, 0);
    check("reset in_ready", in_ready, 0);
    check("reset addr", round_key_addr, 0);
    rst = 1'b0;
    step();

    run(PT, 2'd0, K128, 4, NOSTALL, 0, CT128, "c1");
    run(PT, 2'd1, K192, 6, NOSTALL, 0, CT192, "c2");
    run(PT, 2'd2, K256, 8, NOSTALL, 0, CT256, "c3");
    run(PT, 2'd3, K256, 8, NOSTALL, 0, CT256, "klen3 clamp");
    run(PT, 2'd0, K128, 4, 5, 3, CT128, "stall");

    // Result held under backpressure, then a second block enters on the draining cycle.
    out_ready = 1'b0;
    load_key(K128, 4);
    send(PT, 2'd0, "bp a");
    wait_result(10, NOSTALL, 0, CT128, "bp a");
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      data_in  = rnd128();
      step();
      if (out_valid !== 1'b1 || data_out !== CT128 || in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    check("bp hold", bad, 0);
    pt_b = rnd128();
    data_in = pt_b; key_len = 2'd0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("b2b in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("b2b a released", out_valid, 0);
    check("b2b busy", busy, 1);
    wait_result(10, NOSTALL, 0, cipher(pt_b, 10), "b2b");
    consume("b2b");

    // Reset in the middle of a block.
    load_key(K128, 4);
    send(PT, 2'd0, "rst");
    for (int i = 0; i < 40 && round_key_addr != 4'd6; i++) step();
    check("rst reached round 6", round_key_addr, 6);
    rst = 1'b1;
    step();
    check("midrst busy", busy, 0);
    check("midrst out_valid", out_valid, 0);
    check("midrst data_out", data_out, 0);
    check("midrst in_ready", in_ready, 0);
    check("midrst addr", round_key_addr, 0);
    rst = 1'b0;
    step();
    check("midrst in_ready after", in_ready, 1);
    run(PT, 2'd0, K128, 4, NOSTALL, 0, CT128, "after rst");

    for (int n = 0; n < 6; n++) begin
      key = {rnd128(), rnd128()};
      kl  = 2'($urandom_range(0, 3));
      nk  = (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8;
      pt  = rnd128();
      load_key(key, nk);
      run(pt, kl, key, nk, int'($urandom_range(0, nk + 6)), int'($urandom_range(0, 3)),
          cipher(pt, nk + 6), "rand");
    end

    // Core limited to AES-128: reserved key_len must fall back to 10 rounds.
    load_key(K128, 4);
    data_in = PT; key_len = 2'd3; in_valid0 = 1'b1;
    check("k0 in_ready", in_ready0, 1);
    step();
    in_valid0 = 1'b0;
    check("k0 busy", busy0, 1);
    edges = 1;
    while (out_valid0 !== 1'b1 && edges < 64) begin
      step();
      edges++;
    end
    check("k0 latency", edges, 12);
    check("k0 data_out", data_out0, CT128);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
